// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: 8 lines of 16-byte blocks, 3-bit tag, 10-bit address space.
// Hits return the instruction combinationally; misses stall the CPU while a block is fetched.
module instruction_cache (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [31:0]  PC,
  output logic [31:0]  INSTRUCTION,
  output logic         BUSYWAIT,
  output logic         MEM_READ,
  output logic [5:0]   MEM_ADDRESS,
  input  logic [127:0] MEM_READDATA,
  input  logic         MEM_BUSYWAIT
);

  typedef enum logic [1:0] {IDLE, FETCH, UPDATE} state_t;

  state_t state, next_state;

  logic [127:0] data_mem [8];
  logic [2:0]   tag_mem  [8];
  logic [7:0]   valid;
  logic [127:0] fill;
  logic         issued;

  logic [2:0] pc_tag;
  logic [2:0] pc_idx;
  logic [1:0] pc_word;
  logic       hit;
  logic       fetch_done;
  logic       unused_pc;

  assign pc_tag      = PC[9:7];
  assign pc_idx      = PC[6:4];
  assign pc_word     = PC[3:2];
  assign unused_pc   = ^{PC[31:10], PC[1:0]};
  assign hit         = valid[pc_idx] && (tag_mem[pc_idx] == pc_tag);
  assign INSTRUCTION = data_mem[pc_idx][pc_word*32 +: 32];
  assign MEM_ADDRESS = PC[9:4];

  // The first FETCH edge only marks the request as issued, so a stale low MEM_BUSYWAIT is never mistaken for data.
  assign fetch_done  = (state == FETCH) && issued && !MEM_BUSYWAIT;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= IDLE;
      issued <= 1'b0;
      valid  <= '0;
    end else begin
      state  <= next_state;
      issued <= (state == FETCH) && !fetch_done;
      if (fetch_done)
        fill <= MEM_READDATA;
      if (state == UPDATE) begin
        data_mem[pc_idx] <= fill;
        tag_mem[pc_idx]  <= pc_tag;
        valid[pc_idx]    <= 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    BUSYWAIT   = 1'b0;
    MEM_READ   = 1'b0;
    case (state)
      IDLE: begin
        BUSYWAIT = !hit;
        if (!hit)
          next_state = FETCH;
      end
      FETCH: begin
        BUSYWAIT = 1'b1;
        MEM_READ = 1'b1;
        if (fetch_done)
          next_state = UPDATE;
      end
      UPDATE: begin
        BUSYWAIT   = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    // Reset silences the CPU stall and any memory request immediately.
    if (RESET) begin
      BUSYWAIT = 1'b0;
      MEM_READ = 1'b0;
    end
  end

endmodule

// File: tb/tb_instruction_cache.sv
// Directed self-checking bench for instruction_cache with a hand-driven busy-wait instruction memory.
module tb_instruction_cache;

  logic         CLK;
  logic         RESET;
  logic [31:0]  PC;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [5:0]   MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;

  int errors = 0;
  int checks = 0;
  int edges;

  localparam logic [127:0] BLK_A   = 128'h0C0B0A09_08070605_04030201_00FF0EE0;
  localparam logic [127:0] BLK_B   = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] BLK_C   = 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000;
  localparam logic [127:0] GARBAGE = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

  instruction_cache dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .PC           (PC),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Step to just after the next rising edge so outputs have settled.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] pc);
    PC = pc;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Memory answers a pending miss: busy for busyEdges sampled edges, then presents blk.
  task automatic serveMiss(input int busyEdges, input logic [127:0] blk, input logic [5:0] expAddr);
    edges = 0;
    MEM_READDATA = GARBAGE;
    tick();
    edges++;
    checkOutput("fetch_memread", {31'd0, MEM_READ}, 32'd1);
    checkOutput("fetch_address", {26'd0, MEM_ADDRESS}, {26'd0, expAddr});
    MEM_BUSYWAIT = 1'b1;
    for (int i = 0; i < busyEdges; i++) begin
      tick();
      edges++;
      checkOutput("busy_stall", {31'd0, BUSYWAIT}, 32'd1);
    end
    MEM_BUSYWAIT = 1'b0;
    MEM_READDATA = blk;
    while (BUSYWAIT !== 1'b0 && edges < 40) begin
      tick();
      edges++;
      MEM_READDATA = GARBAGE;
    end
    checkOutput("miss_edges", edges, busyEdges + 3);
    checkOutput("after_memread", {31'd0, MEM_READ}, 32'd0);
  endtask

  initial begin
    RESET        = 1'b1;
    PC           = 32'h0;
    MEM_READDATA = '0;
    MEM_BUSYWAIT = 1'b0;
    tick();
    tick();
    checkOutput("reset_busywait", {31'd0, BUSYWAIT}, 32'd0);
    checkOutput("reset_memread", {31'd0, MEM_READ}, 32'd0);

    // First fill of line 0 with five busy edges.
    RESET = 1'b0;
    applyStimulus(32'h0000_0000);
    checkOutput("miss0_busywait", {31'd0, BUSYWAIT}, 32'd1);
    checkOutput("miss0_address", {26'd0, MEM_ADDRESS}, 32'h0);
    serveMiss(5, BLK_A, 6'h00);
    checkOutput("miss0_instr", INSTRUCTION, 32'h00FF0EE0);
    tick();

    // Remaining words of the block hit with no stall.
    applyStimulus(32'h0000_0004);
    checkOutput("hit4_busywait", {31'd0, BUSYWAIT}, 32'd0);
    checkOutput("hit4_instr", INSTRUCTION, 32'h04030201);
    checkOutput("hit4_memread", {31'd0, MEM_READ}, 32'd0);
    tick();
    applyStimulus(32'h0000_0008);
    checkOutput("hit8_busywait", {31'd0, BUSYWAIT}, 32'd0);
    checkOutput("hit8_instr", INSTRUCTION, 32'h08070605);
    tick();
    applyStimulus(32'h0000_000F);
    checkOutput("hitC_busywait", {31'd0, BUSYWAIT}, 32'd0);
    checkOutput("hitC_instr", INSTRUCTION, 32'h0C0B0A09);
    checkOutput("hitC_memread", {31'd0, MEM_READ}, 32'd0);
    tick();

    // Upper PC bits alias onto the same line.
    applyStimulus(32'hFFFF_FC00);
    checkOutput("alias_busywait", {31'd0, BUSYWAIT}, 32'd0);
    checkOutput("alias_instr", INSTRUCTION, 32'h00FF0EE0);
    tick();

    // Conflict on index 0: tag 1 evicts tag 0, then tag 0 evicts it back.
    applyStimulus(32'h0000_0080);
    checkOutput("conflict1_busywait", {31'd0, BUSYWAIT}, 32'd1);
    serveMiss(2, BLK_B, 6'h08);
    checkOutput("conflict1_instr", INSTRUCTION, 32'h44444444);
    tick();
    applyStimulus(32'h0000_008C);
    checkOutput("conflict1_word3", INSTRUCTION, 32'h11111111);
    tick();
    applyStimulus(32'h0000_0000);
    checkOutput("conflict0_busywait", {31'd0, BUSYWAIT}, 32'd1);
    serveMiss(1, BLK_A, 6'h00);
    checkOutput("zerowait_instr", INSTRUCTION, 32'h00FF0EE0);
    tick();

    // Reset during FETCH abandons the fill and invalidates every line.
    applyStimulus(32'h0000_0010);
    checkOutput("abort_busywait", {31'd0, BUSYWAIT}, 32'd1);
    tick();
    checkOutput("abort_fetch_memread", {31'd0, MEM_READ}, 32'd1);
    RESET = 1'b1;
    #1;
    checkOutput("abort_reset_busywait", {31'd0, BUSYWAIT}, 32'd0);
    tick();
    checkOutput("abort_post_memread", {31'd0, MEM_READ}, 32'd0);
    checkOutput("abort_post_busywait", {31'd0, BUSYWAIT}, 32'd0);
    RESET = 1'b0;
    #1;
    checkOutput("abort_remiss", {31'd0, BUSYWAIT}, 32'd1);
    serveMiss(3, BLK_C, 6'h01);
    checkOutput("abort_refill_instr", INSTRUCTION, 32'hCAFE0000);
    tick();
    applyStimulus(32'h0000_0018);
    checkOutput("line1_word2", INSTRUCTION, 32'hCAFE0002);
    checkOutput("line1_busywait", {31'd0, BUSYWAIT}, 32'd0);
    tick();
    applyStimulus(32'h0000_0000);
    checkOutput("line0_invalidated", {31'd0, BUSYWAIT}, 32'd1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
